// File: rtl/fmr_pkg.sv
// Shared definitions for the 5-way redundancy fault manager.
// Contents: replica count, health state encoding, popcount helper.
package fmr_pkg;

  localparam int FMR_N = 5;

  typedef enum logic [1:0] {
    FMR_RUN      = 2'd0,
    FMR_DEGRADED = 2'd1,
    FMR_FAILSAFE = 2'd2
  } fmr_state_e;

  function automatic logic [2:0] popcount5(input logic [FMR_N-1:0] v);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < FMR_N; i++) begin
      cnt = cnt + {2'd0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/fmr_fault_manager_if.sv
// Bus between the replica bank / control and the fault manager.
// Handshake: sample_valid qualifies X for one cycle; there is no ready,
// the manager accepts every valid sample. a_valid pulses one cycle per
// accepted sample, one edge later, with a carrying the voted bit.
//   sample_valid, X, cfg_clear : toward the manager
//   g, a, a_valid, state, alarm: from the manager (all registered)
interface fmr_fault_manager_if;
  import fmr_pkg::*;

  logic             sample_valid;
  logic [FMR_N-1:0] X;
  logic             cfg_clear;
  logic [FMR_N-1:0] g;
  logic             a;
  logic             a_valid;
  logic [1:0]       state;
  logic             alarm;

  modport slave (
    input  sample_valid, X, cfg_clear,
    output g, a, a_valid, state, alarm
  );

  modport master (
    output sample_valid, X, cfg_clear,
    input  g, a, a_valid, state, alarm
  );
endinterface

// File: rtl/fmr_vote_core.sv
// Combinational masked majority vote with tie detection.
// Ports:
//   i_x      : replica outputs
//   i_g      : enable mask (1 = replica participates)
//   i_a_prev : previously voted bit, returned on a tie
//   o_vote   : voted bit
//   o_tie    : enabled ones are exactly half the enabled replicas
module fmr_vote_core
  import fmr_pkg::*;
(
  input  logic [FMR_N-1:0] i_x,
  input  logic [FMR_N-1:0] i_g,
  input  logic             i_a_prev,
  output logic             o_vote,
  output logic             o_tie
);

  logic [2:0] w_ones;
  logic [2:0] w_act;
  logic [3:0] w_ones_x2;
  logic [3:0] w_act_ext;

  assign w_ones    = popcount5(i_x & i_g);
  assign w_act     = popcount5(i_g);
  assign w_ones_x2 = {w_ones, 1'b0};
  assign w_act_ext = {1'b0, w_act};

  // An empty mask also reads as a tie, so the output simply holds.
  assign o_tie  = (w_ones_x2 == w_act_ext);
  assign o_vote = o_tie ? i_a_prev : (w_ones_x2 > w_act_ext);

endmodule

// File: rtl/fmr_fault_manager.sv
// Fault manager for the 5-replica voter path: votes each valid sample,
// tracks consecutive mismatches per enabled replica, masks replicas that
// reach MISMATCH_LIMIT and reports health (RUN / DEGRADED / FAILSAFE).
// Optional feature macro: FMR_RECOVERY_EN -- masked replicas that agree
// for RECOVER_LIMIT consecutive samples are re-enabled (not in FAILSAFE).
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : fmr_fault_manager_if.slave (sample in, vote/mask/health out)
module fmr_fault_manager
  import fmr_pkg::*;
#(
  parameter int MISMATCH_LIMIT = 4,
  parameter int RECOVER_LIMIT  = 16,
  parameter int MIN_ACTIVE     = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fmr_fault_manager_if.slave   bus
);

  localparam logic [3:0] LP_MM_LIMIT   = 4'(MISMATCH_LIMIT);
  localparam logic [2:0] LP_MIN_ACTIVE = 3'(MIN_ACTIVE);

  fmr_state_e             r_state;
  fmr_state_e             w_state_nxt;
  logic [FMR_N-1:0]       r_g;
  logic [FMR_N-1:0]       w_g_nxt;
  logic [FMR_N-1:0][3:0]  r_mm;
  logic [FMR_N-1:0][3:0]  w_mm_nxt;
  logic                   r_a;
  logic                   w_a_nxt;
  logic                   r_a_valid;
  logic                   w_vote;
  logic                   w_tie;
  logic [2:0]             w_act_nxt;
  logic [3:0]             w_mm_inc;
`ifdef FMR_RECOVERY_EN
  localparam logic [4:0] LP_RC_LIMIT = 5'(RECOVER_LIMIT);
  logic [FMR_N-1:0][4:0]  r_ag;
  logic [FMR_N-1:0][4:0]  w_ag_nxt;
  logic [4:0]             w_ag_inc;
`endif

  fmr_vote_core u_vote (
    .i_x      (bus.X),
    .i_g      (r_g),
    .i_a_prev (r_a),
    .o_vote   (w_vote),
    .o_tie    (w_tie)
  );

  // Vote value of this sample; FAILSAFE freezes the voted bit.
  always_comb begin
    w_a_nxt = r_a;
    if (bus.sample_valid && (r_state != FMR_FAILSAFE)) begin
      w_a_nxt = w_vote;
    end
  end

  // Mask and counter next values. Replicas are compared against the new
  // vote, which on a tie is the held bit.
  always_comb begin
    w_g_nxt  = r_g;
    w_mm_nxt = r_mm;
    w_mm_inc = 4'd0;
`ifdef FMR_RECOVERY_EN
    w_ag_nxt = r_ag;
    w_ag_inc = 5'd0;
`endif
    if (bus.cfg_clear) begin
      w_g_nxt  = '1;
      w_mm_nxt = '0;
`ifdef FMR_RECOVERY_EN
      w_ag_nxt = '0;
`endif
    end else if (bus.sample_valid) begin
      for (int i = 0; i < FMR_N; i++) begin
        if (r_g[i]) begin
          if (bus.X[i] != w_a_nxt) begin
            w_mm_inc    = (r_mm[i] == 4'd15) ? 4'd15 : r_mm[i] + 4'd1;
            w_mm_nxt[i] = w_mm_inc;
            if (w_mm_inc == LP_MM_LIMIT) begin
              w_g_nxt[i] = 1'b0;
            end
          end else begin
            w_mm_nxt[i] = 4'd0;
          end
`ifdef FMR_RECOVERY_EN
        end else if (r_state != FMR_FAILSAFE) begin
          if (bus.X[i] == w_a_nxt) begin
            w_ag_inc = (r_ag[i] == 5'd31) ? 5'd31 : r_ag[i] + 5'd1;
            if (w_ag_inc == LP_RC_LIMIT) begin
              w_g_nxt[i]  = 1'b1;
              w_mm_nxt[i] = 4'd0;
              w_ag_nxt[i] = 5'd0;
            end else begin
              w_ag_nxt[i] = w_ag_inc;
            end
          end else begin
            w_ag_nxt[i] = 5'd0;
          end
`endif
        end
      end
    end
  end

  // Health FSM next state, derived from the next mask. FAILSAFE is sticky.
  assign w_act_nxt = popcount5(w_g_nxt);

  always_comb begin
    w_state_nxt = r_state;
    if (bus.cfg_clear) begin
      w_state_nxt = FMR_RUN;
    end else if (r_state != FMR_FAILSAFE) begin
      if (w_act_nxt == 3'd5) begin
        w_state_nxt = FMR_RUN;
      end else if (w_act_nxt >= LP_MIN_ACTIVE) begin
        w_state_nxt = FMR_DEGRADED;
      end else begin
        w_state_nxt = FMR_FAILSAFE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= FMR_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_g       <= '1;
      r_mm      <= '0;
      r_a       <= 1'b0;
      r_a_valid <= 1'b0;
`ifdef FMR_RECOVERY_EN
      r_ag      <= '0;
`endif
    end else begin
      r_g       <= w_g_nxt;
      r_mm      <= w_mm_nxt;
      r_a       <= w_a_nxt;
      r_a_valid <= bus.sample_valid;
`ifdef FMR_RECOVERY_EN
      r_ag      <= w_ag_nxt;
`endif
    end
  end

  assign bus.g       = r_g;
  assign bus.a       = r_a;
  assign bus.a_valid = r_a_valid;
  assign bus.state   = r_state;
  assign bus.alarm   = (r_state == FMR_FAILSAFE);

endmodule

// File: tb/tb_fmr_fault_manager.sv
// Directed self-checking bench for fmr_fault_manager.
module tb_fmr_fault_manager;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic exp_q[$];

  fmr_fault_manager_if bus ();

  fmr_fault_manager dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- drivers ----------------
  // Drive for one edge, then sample 1 time unit after that edge.
  task automatic step(input logic v, input logic [4:0] x, input logic clr);
    bus.sample_valid = v;
    bus.X            = x;
    bus.cfg_clear    = clr;
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
    bus.cfg_clear    = 1'b0;
  endtask

  task automatic vec(input string tag, input logic [4:0] x, input logic exp_a,
                     input logic [4:0] exp_g, input logic [1:0] exp_st);
    step(1'b1, x, 1'b0);
    check({tag, ".a"},     8'(bus.a),       8'(exp_a));
    check({tag, ".av"},    8'(bus.a_valid), 8'd1);
    check({tag, ".g"},     8'(bus.g),       8'(exp_g));
    check({tag, ".st"},    8'(bus.state),   8'(exp_st));
    check({tag, ".alarm"}, 8'(bus.alarm),   8'(exp_st == 2'd2));
  endtask

  task automatic clear_only(input string tag, input logic exp_a);
    step(1'b0, 5'b00000, 1'b1);
    check({tag, ".g"},  8'(bus.g),       8'h1f);
    check({tag, ".st"}, 8'(bus.state),   8'd0);
    check({tag, ".av"}, 8'(bus.a_valid), 8'd0);
    check({tag, ".a"},  8'(bus.a),       8'(exp_a));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] x;
    logic       e;
    n_checks = 0;
    n_errors = 0;
    bus.sample_valid = 1'b0;
    bus.X            = 5'b00000;
    bus.cfg_clear    = 1'b0;
    rst_n            = 1'b0;
    step(1'b1, 5'b11111, 1'b0);
    step(1'b0, 5'b00000, 1'b0);
    rst_n = 1'b1;
    check("rst.g",     8'(bus.g),       8'h1f);
    check("rst.a",     8'(bus.a),       8'd0);
    check("rst.av",    8'(bus.a_valid), 8'd0);
    check("rst.st",    8'(bus.state),   8'd0);
    check("rst.alarm", 8'(bus.alarm),   8'd0);

    // All agree, alternating; expected bits go through the queue.
    for (int i = 0; i < 10; i++) begin
      x = (i % 2 == 0) ? 5'b11111 : 5'b00000;
      exp_q.push_back(i % 2 == 0);
      step(1'b1, x, 1'b0);
      e = exp_q.pop_front();
      check("agree.a",  8'(bus.a),       8'(e));
      check("agree.av", 8'(bus.a_valid), 8'd1);
    end
    check("agree.g",  8'(bus.g),     8'h1f);
    check("agree.st", 8'(bus.state), 8'd0);
    step(1'b0, 5'b00000, 1'b0);
    check("agree.av_drop", 8'(bus.a_valid), 8'd0);

    // Single fault on replica 2, alternating polarity.
    vec("sf1", 5'b11011, 1'b1, 5'b11111, 2'd0);
    vec("sf2", 5'b00100, 1'b0, 5'b11111, 2'd0);
    vec("sf3", 5'b11011, 1'b1, 5'b11111, 2'd0);
    vec("sf4", 5'b00100, 1'b0, 5'b11011, 2'd1);
    vec("sf5", 5'b00000, 1'b0, 5'b11011, 2'd1);

    // Intermittent fault on replica 0: no masking.
    clear_only("clr1", 1'b0);
    vec("im1", 5'b11110, 1'b1, 5'b11111, 2'd0);
    vec("im2", 5'b11110, 1'b1, 5'b11111, 2'd0);
    vec("im3", 5'b11110, 1'b1, 5'b11111, 2'd0);
    vec("im4", 5'b11111, 1'b1, 5'b11111, 2'd0);
    vec("im5", 5'b11110, 1'b1, 5'b11111, 2'd0);
    vec("im6", 5'b11110, 1'b1, 5'b11111, 2'd0);
    vec("im7", 5'b11110, 1'b1, 5'b11111, 2'd0);

    // Cascade to FAILSAFE.
    clear_only("clr2", 1'b1);
    for (int i = 0; i < 4; i++)
      vec("cs3", 5'b10111, 1'b1, (i == 3) ? 5'b10111 : 5'b11111, (i == 3) ? 2'd1 : 2'd0);
    for (int i = 0; i < 4; i++)
      vec("cs4", 5'b01111, 1'b1, (i == 3) ? 5'b00111 : 5'b10111, 2'd1);
    for (int i = 0; i < 4; i++)
      vec("cs1", 5'b11101, 1'b1, (i == 3) ? 5'b00101 : 5'b00111, (i == 3) ? 2'd2 : 2'd1);
    vec("fs_frozen", 5'b00000, 1'b1, 5'b00101, 2'd2);
    vec("fs_sticky", 5'b11111, 1'b1, 5'b00101, 2'd2);

    // Tie handling and cfg_clear with a simultaneous sample.
    clear_only("clr3", 1'b1);
    for (int i = 0; i < 4; i++)
      vec("m0", 5'b11110, 1'b1, (i == 3) ? 5'b11110 : 5'b11111, (i == 3) ? 2'd1 : 2'd0);
    vec("tie_hold1", 5'b00110, 1'b1, 5'b11110, 2'd1);
    vec("to_zero",   5'b00000, 1'b0, 5'b11110, 2'd1);
    vec("tie_hold0", 5'b11000, 1'b0, 5'b11110, 2'd1);
    step(1'b1, 5'b01000, 1'b1);
    check("clrs.a",  8'(bus.a),       8'd0);
    check("clrs.av", 8'(bus.a_valid), 8'd1);
    check("clrs.g",  8'(bus.g),       8'h1f);
    check("clrs.st", 8'(bus.state),   8'd0);
    // Counters must be zero: replica 3 needs four fresh mismatches.
    vec("cz1", 5'b10111, 1'b1, 5'b11111, 2'd0);
    vec("cz2", 5'b10111, 1'b1, 5'b11111, 2'd0);
    vec("cz3", 5'b10111, 1'b1, 5'b11111, 2'd0);
    vec("cz4", 5'b10111, 1'b1, 5'b10111, 2'd1);

    // Recovery (or permanent masking) of replica 2.
    clear_only("clr4", 1'b1);
    for (int i = 0; i < 4; i++)
      vec("rm2", 5'b11011, 1'b1, (i == 3) ? 5'b11011 : 5'b11111, (i == 3) ? 2'd1 : 2'd0);
    for (int i = 0; i < 15; i++)
      vec("rc", 5'b11111, 1'b1, 5'b11011, 2'd1);
`ifdef FMR_RECOVERY_EN
    vec("rc16", 5'b11111, 1'b1, 5'b11111, 2'd0);
`else
    vec("rc16", 5'b11111, 1'b1, 5'b11011, 2'd1);
`endif

    // Reset mid-operation with an in-flight sample.
    rst_n = 1'b0;
    step(1'b1, 5'b11111, 1'b0);
    rst_n = 1'b1;
    check("mrst.av", 8'(bus.a_valid), 8'd0);
    check("mrst.a",  8'(bus.a),       8'd0);
    check("mrst.g",  8'(bus.g),       8'h1f);
    check("mrst.st", 8'(bus.state),   8'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
